chute_briques: RTL
==================

# chute_briques

Falling-brick engine for the three-column stacking game. It is the other end of the column controller. It consumes the controller's column output and produces the brick row and the three stack heights that the controller uses to validate moves. The block times the brick's fall, detects landing, grows the stacks, clears a completed bottom row, spawns the next brick and flags game over.

## Interface
- `TICK_DIV`, 25_000_000 — clock cycles per fall step at normal speed.
- `TICK_RAPIDE`, 2_500_000 — clock cycles per fall step while `chute_rapide` is high.
- `HAUTEUR_MAX`, 7 — spawn row, and the highest representable stack height.
- `clk` in 1 — system clock; all state changes on the rising edge.
- `reset` in 1 — reset, synchronous, active-high; clock clk.
- `col` in 2 — current brick column from the controller: 0 = left, 1 = centre, 2 = right.
- `chute_rapide` in 1 — soft drop; selects `TICK_RAPIDE` as the fall period.
- `row` out 3 — brick row, 0 = bottom.
- `hauteurGauche` out 3 — left stack height (number of filled cells).
- `hauteurCentre` out 3 — centre stack height.
- `hauteurDroite` out 3 — right stack height.
- `nouvelle_brique` out 1 — one-cycle pulse when a brick spawns.
- `posee` out 1 — one-cycle pulse when a brick lands.
- `lignes` out 8 — cleared-row count, saturating at 255.
- `game_over` out 1 — sticky until `reset`.

## Operation
- Stack model: height h means cells 0..h-1 are filled. A brick at `row` r in column c rests when r <= h[c].
- Column latch: `col` is registered each cycle only when `col` <= 2. The value 3 is ignored and the previous column is held. The reset value of the latch is 1.
- State SPAWN (1 cycle):
  - `row` <= `HAUTEUR_MAX`, tick counter <= 0, `nouvelle_brique` = 1.
  - Next state: FALL.
- State FALL:
  - The tick counter increments each cycle.
  - The period P is `TICK_RAPIDE` if `chute_rapide` is high, otherwise `TICK_DIV`.
  - A tick occurs when counter >= P-1; the counter then returns to 0.
  - On a tick, if `row` <= h[latched col], go to LAND. Otherwise `row` <= `row` - 1.
- State LAND (1 cycle), `posee` = 1:
  - If `row` == `HAUTEUR_MAX`: go to GAME_OVER. Heights are not modified (no overflow past 7).
  - Otherwise h[col] <= h[col] + 1, then go to CHECK.
- State CHECK (1 cycle):
  - If all three heights are >= 1, each height is decremented by 1 and `lignes` increments, saturating at 255.
  - Next state: SPAWN.
  - Only one row is cleared per landing.
- State GAME_OVER:
  - `game_over` = 1.
  - `row`, heights and `lignes` are frozen.
  - Inputs are ignored until `reset`.
- Protocol violation: if `row` < h[col] because `col` jumped, the brick lands on the current top (h[col] + 1), not at `row`.

## Timing
- Reset values: `row` = 7, all heights = 0, `lignes` = 0, `game_over` = 0, `nouvelle_brique` = 0, `posee` = 0, state = SPAWN, tick counter = 0.
- `reset` mid-operation overrides every state, including GAME_OVER, on the same edge.
- The first cycle after `reset` deasserts is SPAWN, so `nouvelle_brique` pulses in that cycle.
- Fall step: `row` changes exactly P cycles after FALL entry, or P cycles after the previous step.
- Landing detection uses the latched column at the tick edge. Column changes between ticks only take effect at the next tick.
- Speed switch mid-count: the comparison is >=, so switching to the shorter period with counter >= `TICK_RAPIDE`-1 ticks on the next edge.
- Landing to next fall: LAND, CHECK and SPAWN take 3 cycles, then FALL.
- Height and `lignes` updates are visible the cycle after LAND and CHECK respectively.
- Pulses are registered and last exactly one cycle.

## Test plan
- `TICK_DIV`=4, `col`=1, `chute_rapide`=0, reset released:
  - `nouvelle_brique` pulses once.
  - `row` steps 7→0 every 4 cycles.
  - The 8th tick (32 cycles after FALL entry) pulses `posee`, then `hauteurCentre`=1.
- Three bricks landed in columns 0, 1 and 2:
  - After the third LAND the heights are 1,1,1.
  - After CHECK the heights are 0,0,0, `lignes`=1 and `nouvelle_brique` pulses.
- `col`=1 held for 8 bricks:
  - Heights go 1..7.
  - The 8th brick lands at `row` 7, so `game_over`=1 and `hauteurCentre` stays 7.
  - `row` stays frozen for 100 cycles.
  - `reset` clears everything.
- `TICK_DIV`=8, `TICK_RAPIDE`=2: assert `chute_rapide` when the counter is at 5 → the tick occurs on the next edge, then every 2 cycles.
- Left stack at height 3, brick in column 0 at `row` 5, `col` driven to 3 → the latched column stays 0 and the brick lands at `row` 3, giving `hauteurGauche`=4.
- `reset` asserted during LAND → heights remain at their pre-landing values, `posee` is 0 on the next cycle and `row`=7.

Source files
------------

// File: rtl/chute_briques.sv
// Falling-brick engine for the three-column stacking game: times the fall,
// detects landing, grows and clears the stacks, spawns bricks, flags game over.
module chute_briques #(
  parameter int TICK_DIV    = 25_000_000,
  parameter int TICK_RAPIDE = 2_500_000,
  parameter int HAUTEUR_MAX = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] col,
  input  logic       chute_rapide,
  output logic [2:0] row,
  output logic [2:0] hauteurGauche,
  output logic [2:0] hauteurCentre,
  output logic [2:0] hauteurDroite,
  output logic       nouvelle_brique,
  output logic       posee,
  output logic [7:0] lignes,
  output logic       game_over
);

  localparam int TMAX = (TICK_DIV > TICK_RAPIDE) ? TICK_DIV : TICK_RAPIDE;
  localparam int CW   = $clog2(TMAX) + 1;
  localparam logic [2:0] HMAX = 3'(HAUTEUR_MAX);

  typedef enum logic [2:0] {
    SPAWN     = 3'd0,
    FALL      = 3'd1,
    LAND      = 3'd2,
    CHECK     = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  state_t state, state_next;

  logic [1:0]    col_lat;
  logic [1:0]    land_col;
  logic [CW-1:0] cnt;
  logic [CW-1:0] limit;
  logic          tick;
  logic [2:0]    h_fall;
  logic [2:0]    h_land;
  logic          all_filled;

  function automatic logic [2:0] height_of(input logic [1:0] sel,
                                           input logic [2:0] hg,
                                           input logic [2:0] hc,
                                           input logic [2:0] hd);
    case (sel)
      2'd0:    height_of = hg;
      2'd1:    height_of = hc;
      default: height_of = hd;
    endcase
  endfunction

  always_comb begin
    limit      = chute_rapide ? CW'(TICK_RAPIDE - 1) : CW'(TICK_DIV - 1);
    tick       = (state == FALL) && (cnt >= limit);
    h_fall     = height_of(col_lat, hauteurGauche, hauteurCentre, hauteurDroite);
    h_land     = height_of(land_col, hauteurGauche, hauteurCentre, hauteurDroite);
    all_filled = (hauteurGauche != 3'd0) && (hauteurCentre != 3'd0) &&
                 (hauteurDroite != 3'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SPAWN;
    else       state <= state_next;
  end

  // A column jump can leave the brick below the stack top; a full target
  // column then ends the game instead of overflowing the height.
  always_comb begin
    state_next = state;
    case (state)
      SPAWN:     state_next = FALL;
      FALL:      if (tick && (row <= h_fall)) state_next = LAND;
                 else                         state_next = FALL;
      LAND:      if ((row == HMAX) || (h_land == HMAX)) state_next = GAME_OVER;
                 else                                   state_next = CHECK;
      CHECK:     state_next = SPAWN;
      GAME_OVER: state_next = GAME_OVER;
      default:   state_next = SPAWN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_lat         <= 2'd1;
      land_col        <= 2'd1;
      cnt             <= '0;
      row             <= HMAX;
      hauteurGauche   <= 3'd0;
      hauteurCentre   <= 3'd0;
      hauteurDroite   <= 3'd0;
      nouvelle_brique <= 1'b0;
      posee           <= 1'b0;
      lignes          <= 8'd0;
      game_over       <= 1'b0;
    end else begin
      nouvelle_brique <= (state == SPAWN);
      posee           <= (state == LAND);
      if (state_next == GAME_OVER) game_over <= 1'b1;
      if ((col != 2'd3) && (state != GAME_OVER)) col_lat <= col;
      case (state)
        SPAWN: begin
          row <= HMAX;
          cnt <= '0;
        end
        FALL: begin
          if (tick) begin
            cnt      <= '0;
            land_col <= col_lat;
            if (row > h_fall) row <= row - 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LAND: begin
          if (state_next == CHECK) begin
            case (land_col)
              2'd0:    hauteurGauche <= hauteurGauche + 3'd1;
              2'd1:    hauteurCentre <= hauteurCentre + 3'd1;
              default: hauteurDroite <= hauteurDroite + 3'd1;
            endcase
          end
        end
        CHECK: begin
          if (all_filled) begin
            hauteurGauche <= hauteurGauche - 3'd1;
            hauteurCentre <= hauteurCentre - 3'd1;
            hauteurDroite <= hauteurDroite - 3'd1;
            if (lignes != 8'hFF) lignes <= lignes + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
